// File: rtl/display_scanner_if.sv
// Bus between a host and the display scanner: value/load/blank control in,
// registered digit drive out.
interface display_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank_lz;
  logic [3:0]          input_code;
  logic [DIGITS-1:0]   digit_enable;
  logic                blank;
  logic                frame_start;

  modport master (
    output value, load, blank_lz,
    input  input_code, digit_enable, blank, frame_start
  );

  modport slave (
    input  value, load, blank_lz,
    output input_code, digit_enable, blank, frame_start
  );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for a multi-digit hex display with
// frame-synchronous double buffering and optional leading-zero blanking.
module display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic            clk,
  input  logic            reset,
  display_scanner_if.slave bus
);
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW  = 4 * DIGITS;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);
  localparam logic [DW-1:0]  D_LAST  = DW'(DIGITS - 1);

  logic [PCW-1:0]    pc;
  logic [DW-1:0]     d;
  logic [VW-1:0]     pend;
  logic [VW-1:0]     disp;

  logic              tick;
  logic              wrap;
  logic [DW-1:0]     d_next;
  logic [VW-1:0]     pend_next;
  logic [VW-1:0]     disp_next;
  logic [3:0]        code_next;
  logic [DIGITS-1:0] en_next;
  logic              upper_zero;
  logic              blank_next;

  // Outputs are computed from next-state digit and display value, so the
  // registered drive never mixes a digit index with another slot's nibble.
  always_comb begin
    tick       = (pc == PC_LAST);
    wrap       = tick && (d == D_LAST);
    d_next     = d;
    if (tick) d_next = wrap ? '0 : d + 1'b1;
    pend_next  = bus.load ? bus.value : pend;
    disp_next  = wrap ? pend_next : disp;
    code_next  = '0;
    en_next    = '0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (d_next == DW'(k)) begin
        code_next  = disp_next[4*k +: 4];
        en_next[k] = 1'b1;
      end
      if (DW'(k) >= d_next && disp_next[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end
    blank_next = bus.blank_lz && (d_next != '0) && upper_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc               <= '0;
      d                <= '0;
      pend             <= '0;
      disp             <= '0;
      bus.input_code   <= '0;
      bus.digit_enable <= DIGITS'(1);
      bus.blank        <= 1'b0;
      bus.frame_start  <= 1'b0;
    end else begin
      pc               <= tick ? '0 : pc + 1'b1;
      d                <= d_next;
      pend             <= pend_next;
      disp             <= disp_next;
      bus.input_code   <= code_next;
      bus.digit_enable <= blank_next ? '0 : en_next;
      bus.blank        <= blank_next;
      bus.frame_start  <= wrap;
    end
  end
endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: two instances (PRESCALE 4 and 1) checked every
// cycle against a slot-arithmetic model, plus directed literal checks.
module tb_display_scanner;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  display_scanner_if #(.DIGITS(4)) bus4 ();
  display_scanner_if #(.DIGITS(4)) bus1 ();

  display_scanner #(.DIGITS(4), .PRESCALE(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  display_scanner #(.DIGITS(4), .PRESCALE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: edges since reset, pending/displayed value, sampled blank_lz.
  int          n4, n1;
  logic [15:0] pend4, disp4, pend1, disp1;
  logic        blz4, blz1;

  // Packs {frame_start, blank, digit_enable, input_code} for edge count n.
  function automatic logic [9:0] expect_out(int n, int p, logic [15:0] dv, logic blz);
    int         dig;
    logic [3:0] code;
    logic       blk;
    logic [3:0] en;
    logic       fs;
    dig  = (n / p) % 4;
    code = 4'((dv >> (4 * dig)) & 16'h000F);
    blk  = blz && (dig > 0) && ((dv >> (4 * dig)) == 16'h0000);
    en   = blk ? 4'b0000 : 4'(1 << dig);
    fs   = (n > 0) && (n % (4 * p) == 0);
    return {fs, blk, en, code};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n4 = 0; pend4 = '0; disp4 = '0; blz4 = 1'b0;
      n1 = 0; pend1 = '0; disp1 = '0; blz1 = 1'b0;
    end else begin
      n4++;
      if (bus4.load) pend4 = bus4.value;
      if (n4 % 16 == 0) disp4 = pend4;
      blz4 = bus4.blank_lz;
      n1++;
      if (bus1.load) pend1 = bus1.value;
      if (n1 % 4 == 0) disp1 = pend1;
      blz1 = bus1.blank_lz;
    end
  end

  task automatic checkOutput(input string name, input logic [9:0] actual, input logic [9:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got fs/blank/en/code=%b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_p4", {bus4.frame_start, bus4.blank, bus4.digit_enable, bus4.input_code},
                expect_out(n4, 4, disp4, blz4));
    checkOutput("model_p1", {bus1.frame_start, bus1.blank, bus1.digit_enable, bus1.input_code},
                expect_out(n1, 1, disp1, blz1));
  end

  task automatic applyStimulus(input logic [15:0] v);
    bus4.value = v;
    bus4.load  = 1'b1;
    @(negedge clk);
    bus4.load  = 1'b0;
  endtask

  function automatic logic [9:0] out4();
    return {bus4.frame_start, bus4.blank, bus4.digit_enable, bus4.input_code};
  endfunction

  function automatic logic [9:0] out1();
    return {bus1.frame_start, bus1.blank, bus1.digit_enable, bus1.input_code};
  endfunction

  logic [3:0] scan4_code [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] scan1_code [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
  logic [3:0] en_tab     [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus4.value = '0; bus4.load = 1'b0; bus4.blank_lz = 1'b0;
    bus1.value = '0; bus1.load = 1'b0; bus1.blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_p4", out4(), {1'b0, 1'b0, 4'b0001, 4'h0});
    checkOutput("reset_p1", out1(), {1'b0, 1'b0, 4'b0001, 4'h0});

    reset = 1'b0;
    bus4.value = 16'h1234; bus4.load = 1'b1;
    bus1.value = 16'h4321; bus1.load = 1'b1;
    @(negedge clk);
    bus4.load = 1'b0;
    bus1.load = 1'b0;
    repeat (15) @(negedge clk);

    // Edges 16..31: first full frame showing the loaded values.
    for (int i = 0; i < 16; i++) begin
      checkOutput("scan_p4", out4(), {i == 0, 1'b0, en_tab[i/4], scan4_code[i/4]});
      checkOutput("scan_p1", out1(), {(i % 4) == 0, 1'b0, en_tab[i%4], scan1_code[i%4]});
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    applyStimulus(16'hABCD);
    repeat (3) @(negedge clk);
    checkOutput("dbuf_d2", out4(), {1'b0, 1'b0, 4'b0100, 4'h2});
    repeat (4) @(negedge clk);
    checkOutput("dbuf_d3", out4(), {1'b0, 1'b0, 4'b1000, 4'h1});
    repeat (4) @(negedge clk);
    checkOutput("dbuf_new", out4(), {1'b1, 1'b0, 4'b0001, 4'hD});

    repeat (15) @(negedge clk);
    applyStimulus(16'h00F0);
    checkOutput("bypass_d0", out4(), {1'b1, 1'b0, 4'b0001, 4'h0});
    repeat (4) @(negedge clk);
    checkOutput("bypass_d1", out4(), {1'b0, 1'b0, 4'b0010, 4'hF});
    bus4.blank_lz = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("blank_d2", out4(), {1'b0, 1'b1, 4'b0000, 4'h0});
    repeat (4) @(negedge clk);
    checkOutput("blank_d3", out4(), {1'b0, 1'b1, 4'b0000, 4'h0});
    repeat (4) @(negedge clk);
    checkOutput("blank_d0", out4(), {1'b1, 1'b0, 4'b0001, 4'h0});

    applyStimulus(16'h0000);
    repeat (15) @(negedge clk);
    checkOutput("zero_d0", out4(), {1'b1, 1'b0, 4'b0001, 4'h0});
    repeat (4) @(negedge clk);
    checkOutput("zero_d1", out4(), {1'b0, 1'b1, 4'b0000, 4'h0});

    applyStimulus(16'h0050);
    repeat (11) @(negedge clk);
    checkOutput("lz50_d0", out4(), {1'b1, 1'b0, 4'b0001, 4'h0});
    repeat (4) @(negedge clk);
    checkOutput("lz50_d1", out4(), {1'b0, 1'b0, 4'b0010, 4'h5});
    repeat (4) @(negedge clk);
    checkOutput("lz50_d2", out4(), {1'b0, 1'b1, 4'b0000, 4'h0});

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_p4", out4(), {1'b0, 1'b0, 4'b0001, 4'h0});
    checkOutput("async_rst_p1", out1(), {1'b0, 1'b0, 4'b0001, 4'h0});
    bus4.blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("first_tick", out4(), {1'b0, 1'b0, 4'b0010, 4'h0});
    repeat (12) @(negedge clk);
    checkOutput("first_frame_p4", out4(), {1'b1, 1'b0, 4'b0001, 4'h0});
    checkOutput("first_frame_p1", out1(), {1'b1, 1'b0, 4'b0001, 4'h0});
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed scan controller for the four-digit alphanumeric display. It captures a 16-bit value as four hex nibbles and cycles through the digits at a programmable rate. Each slot it presents one nibble as `input_code` to the downstream `display_decoder`, together with a one-hot digit enable. Value updates are double-buffered and take effect only at a frame boundary, and optional leading-zero blanking is supported.

## Interface
- `DIGITS`, 4: number of digits scanned; nibble k of the display register drives digit k (digit 0 = least significant).
- `PRESCALE`, 1000: clock cycles each digit is held; legal range 1..65535.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  one clock; reset is asynchronous and active-high.
- `value`  input  4*DIGITS  hex value to display.
- `load`  input  1  single-cycle strobe; captures `value` into the pending register.
- `blank_lz`  input  1  when high, leading zero digits are blanked.
- `input_code`  output  4  nibble for the current digit; feeds `display_decoder.input_code`.
- `digit_enable`  output  DIGITS  one-hot active-high digit drive; all zero while the current digit is blanked.
- `blank`  output  1  high while the current digit is blanked; segment drivers gate on it.
- `frame_start`  output  1  one-cycle pulse on the cycle digit 0 becomes active.

## Operation
- State:
  - prescale counter `pc` (0..PRESCALE-1)
  - digit index `d` (0..DIGITS-1)
  - pending register `pend`
  - display register `disp`
  - all outputs registered
- Reset (async, immediate): `pc`=0, `d`=0, `pend`=0, `disp`=0, `input_code`=0, `digit_enable`=1 (digit 0 only), `blank`=0, `frame_start`=0.
- `tick` = (`pc`==PRESCALE-1).
  - On `tick`: `pc`→0 and `d`→(`d`+1) mod DIGITS.
  - Otherwise `pc` increments.
  - With PRESCALE=1, `tick` is asserted every cycle.
- `load` high: `pend`←`value` on that edge. Repeated loads within a frame overwrite `pend`; only the last one counts.
- Frame boundary (`tick` with `d`==DIGITS-1): `disp`←`pend`.
  - If `load` is also high on that edge, `disp` and `pend` both take `value` directly (bypass).
- Output registers are loaded on every edge from the next-state `d'` and `disp'`:
  - `input_code` = nibble `d'` of `disp'`.
  - `digit_enable` = one-hot(`d'`), or 0 when blanked.
  - `blank` = blank condition for (`d'`, `disp'`).
  - `frame_start` = 1 only on the edge where `d` wraps from DIGITS-1 to 0.
- Blank condition: `blank_lz`=1, `d'`>0, and nibbles `d'`..DIGITS-1 of `disp'` are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - `input_code` still carries the nibble (0) while blanked.
- `blank_lz` is sampled every cycle; a change affects the next output update without waiting for a frame boundary.
- `value` is ignored unless `load` is high.

## Timing
- Each digit is active for exactly PRESCALE cycles; one frame = DIGITS*PRESCALE cycles.
- Output latency is one cycle from a state change. Outputs never show a digit index and nibble from different slots.
- Load-to-display latency: the new value appears at the next `frame_start`, i.e. between 1 and DIGITS*PRESCALE cycles after the `load` edge. It is never visible mid-frame.
- After reset deassertion, the first `tick` occurs PRESCALE cycles later and the first `frame_start` occurs DIGITS*PRESCALE cycles later.
- Reset asserted mid-frame: all state clears immediately and the pending value is lost; the scan restarts at digit 0 on release.
- `d` is only written on `tick`. Counter width is the minimum needed for PRESCALE-1, and wrap is exact with no overshoot.

## Test plan
- Reset: PRESCALE=4, assert `reset` mid-scan → `digit_enable`=0001, `input_code`=0, `blank`=0, `frame_start`=0 immediately, with no clock edge required.
- Scan rate: PRESCALE=4, load 16'h1234 → after the first frame boundary, each digit is held 4 cycles: 0001/4, 0010/3, 0100/2, 1000/1; `frame_start` pulses every 16 cycles.
- Double buffering: displaying 16'h1234, load 16'hABCD while digit 1 is active → digits 2 and 3 still show 2 and 1; at the next `frame_start`, digit 0 shows D.
- Load at boundary: assert `load`=16'h00F0 on the wrap edge → the frame starting on that edge shows 0/F/0/0; the displayed value is not 16'h1234.
- Leading-zero blanking: disp=16'h0050, `blank_lz`=1 → digits 3 and 2 have `blank`=1 and `digit_enable`=0; digits 1 and 0 show 5 and 0. With disp=0, only digit 0 is lit, showing 0.
- PRESCALE=1: load 16'h4321 → the digit advances every cycle, `frame_start` pulses every 4 cycles, and `input_code` sequence is 1,2,3,4.
